// File: rtl/uart_vga_pkg.sv
// Shared constants, FSM state type and line payload for the UART-to-VGA frame path.
//   WIGHT/HEIGHT : frame geometry in pixels / lines
//   PIX_W        : bits per pixel, ROW_W: line index width, ADDR_W: frame RAM address width
//   lw_state_t   : line writer FSM states
//   line_t       : one captured UART line (row index + packed pixels, pixel x at [PIX_W*x +: PIX_W])
package uart_vga_pkg;

  localparam int unsigned WIGHT  = 640;
  localparam int unsigned HEIGHT = 480;
  localparam int unsigned PIX_W  = 3;
  localparam int unsigned ROW_W  = 9;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned LINE_W = PIX_W * WIGHT;
  localparam int unsigned X_W    = $clog2(WIGHT);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE
  } lw_state_t;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [LINE_W-1:0] data;
  } line_t;

endpackage

// File: rtl/uart_line_slot.sv
// One-line holding register with a valid flag.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture d and set valid (wins over clear)
//   clear    : drop valid
//   d, q     : line payload in / held payload out
//   valid    : q holds a line not yet consumed
module uart_line_slot
  import uart_vga_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clear,
  input  line_t d,
  output line_t q,
  output logic  valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_line_writer.sv
// Captures a completed UART line on `done` and serialises it into single-pixel
// frame RAM writes at row*WIGHT + x, issuing a write only when the arbiter grants one.
//   clk, rst   : clock, synchronous active-high reset
//   done       : row/line_data valid this cycle
//   row        : target line, line_data: packed pixels
//   wr_allow   : arbiter write grant
//   ram_write  : write strobe (combinational), ram_addr/ram_data: registered write port
//   busy       : a line is being written, line_done: pulse after the last pixel
//   row_err    : pulse for a done with row >= HEIGHT, drop_cnt: saturating lost-line count
// Build option: UART_LINE_WRITER_DBL_BUF_EN adds a one-line pending slot so a line
// arriving while busy is held instead of dropped.
module uart_line_writer
  import uart_vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [ROW_W-1:0]  row,
  input  logic [LINE_W-1:0] line_data,
  input  logic              wr_allow,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_data,
  output logic              busy,
  output logic              line_done,
  output logic              row_err,
  output logic [7:0]        drop_cnt
);

  lw_state_t         state;
  logic [LINE_W-1:0] shreg;
  logic [X_W-1:0]    x;
  line_t             new_line;
  line_t             act_d;
  line_t             act_q;
  logic              act_load;
  logic              act_clr;
  logic              act_valid;
  logic              drop;
  logic              line_ok;

  // Out-of-range rows are rejected before any slot sees them.
  assign line_ok  = done && (row < ROW_W'(HEIGHT));
  assign new_line = '{row: row, data: line_data};
  assign act_clr  = (state == LOAD);

`ifdef UART_LINE_WRITER_DBL_BUF_EN
  line_t pend_q;
  logic  pend_load;
  logic  pend_clr;
  logic  pend_valid;

  // IDLE promotes the pending line; a same-cycle done refills the freed slot.
  always_comb begin
    act_load  = 1'b0;
    act_d     = new_line;
    pend_load = 1'b0;
    pend_clr  = 1'b0;
    drop      = 1'b0;
    if (state == IDLE) begin
      if (pend_valid) begin
        act_load  = 1'b1;
        act_d     = pend_q;
        pend_clr  = 1'b1;
        pend_load = line_ok;
      end else if (line_ok) begin
        act_load = 1'b1;
      end
    end else if (line_ok) begin
      if (pend_valid) drop      = 1'b1;
      else            pend_load = 1'b1;
    end
  end

  uart_line_slot u_pend_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (pend_load),
    .clear (pend_clr),
    .d     (new_line),
    .q     (pend_q),
    .valid (pend_valid)
  );
`else
  // Single buffer: anything arriving while busy is lost.
  always_comb begin
    act_load = 1'b0;
    act_d    = new_line;
    drop     = 1'b0;
    if (state == IDLE) act_load = line_ok;
    else               drop     = line_ok;
  end
`endif

  uart_line_slot u_act_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (act_load),
    .clear (act_clr),
    .d     (act_d),
    .q     (act_q),
    .valid (act_valid)
  );

  assign ram_write = (state == WRITE) && wr_allow;

  // Line writer FSM and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ram_addr  <= '0;
      ram_data  <= '0;
      shreg     <= '0;
      x         <= '0;
      busy      <= 1'b0;
      line_done <= 1'b0;
      row_err   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      line_done <= 1'b0;
      row_err   <= done && (row >= ROW_W'(HEIGHT));
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (act_load) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (act_valid) begin
            ram_addr <= ADDR_W'(act_q.row) * ADDR_W'(WIGHT);
            ram_data <= act_q.data[PIX_W-1:0];
            shreg    <= act_q.data >> PIX_W;
            x        <= '0;
            state    <= WRITE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WRITE: begin
          if (wr_allow) begin
            if (x == X_W'(WIGHT - 1)) begin
              state     <= IDLE;
              busy      <= 1'b0;
              line_done <= 1'b1;
            end else begin
              ram_addr <= ram_addr + ADDR_W'(1);
              ram_data <= shreg[PIX_W-1:0];
              shreg    <= shreg >> PIX_W;
              x        <= x + X_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
